sram_ring_buffer: RTL

//  Parametrised SRAM staging buffer between the AHB subordinate, the accelerator controller and the SRAM model.

---
 rtl/sram_ring_buffer_if.sv | 53 +++++
 rtl/sram_ring_buffer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_ring_buffer_if.sv
// Bus bundle for sram_ring_buffer: AHB write/read, activation FIFO and SRAM port.
// slave = buffer side, master = surrounding system side.
interface sram_ring_buffer_if #(
    parameter int DATA_W  = 64,
    parameter int SRAM_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int W_DEPTH = 8,
    parameter int I_DEPTH = 128,
    parameter int O_DEPTH = 128
);
    logic                           clear;
    logic                           wr_req;
    logic                           wr_is_weight;
    logic [DATA_W-1:0]              wr_data;
    logic                           wr_ack;
    logic                           rd_w_req;
    logic                           rd_i_req;
    logic                           rd_valid;
    logic                           rd_ack;
    logic [DATA_W-1:0]              rd_data;
    logic                           act_valid;
    logic [DATA_W-1:0]              act_data;
    logic                           out_valid;
    logic                           out_ready;
    logic [DATA_W-1:0]              out_data;
    logic [$clog2(W_DEPTH+1)-1:0]   w_count;
    logic [$clog2(I_DEPTH+1)-1:0]   i_count;
    logic [$clog2(O_DEPTH+1)-1:0]   o_count;
    logic                           occ_err;
    logic [1:0]                     err_code;
    logic                           sram_wen;
    logic                           sram_ren;
    logic [ADDR_W-1:0]              sram_addr;
    logic [SRAM_W-1:0]              sram_wdata;
    logic [SRAM_W-1:0]              sram_rdata;
    logic [1:0]                     sram_state;

    modport slave (
        input  clear, wr_req, wr_is_weight, wr_data, rd_w_req, rd_i_req,
        input  rd_ack, act_valid, act_data, out_ready, sram_rdata, sram_state,
        output wr_ack, rd_valid, rd_data, out_valid, out_data,
        output w_count, i_count, o_count, occ_err, err_code,
        output sram_wen, sram_ren, sram_addr, sram_wdata
    );

    modport master (
        output clear, wr_req, wr_is_weight, wr_data, rd_w_req, rd_i_req,
        output rd_ack, act_valid, act_data, out_ready, sram_rdata, sram_state,
        input  wr_ack, rd_valid, rd_data, out_valid, out_data,
        input  w_count, i_count, o_count, occ_err, err_code,
        input  sram_wen, sram_ren, sram_addr, sram_wdata
    );
endinterface

// File: rtl/sram_ring_buffer.sv
// SRAM staging buffer: weight/input circular queues in SRAM, split into beats,
// plus a register-based activation output FIFO.
module sram_ring_buffer #(
    parameter int DATA_W  = 64,
    parameter int SRAM_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int W_DEPTH = 8,
    parameter int I_DEPTH = 128,
    parameter int O_DEPTH = 128
) (
    input  logic              clk,
    input  logic              n_rst,
    sram_ring_buffer_if.slave bus
);
    localparam int BEATS  = DATA_W / SRAM_W;
    localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WPW    = (W_DEPTH > 1) ? $clog2(W_DEPTH) : 1;
    localparam int IPW    = (I_DEPTH > 1) ? $clog2(I_DEPTH) : 1;
    localparam int OPW    = (O_DEPTH > 1) ? $clog2(O_DEPTH) : 1;
    localparam int WCW    = $clog2(W_DEPTH + 1);
    localparam int ICW    = $clog2(I_DEPTH + 1);
    localparam int OCW    = $clog2(O_DEPTH + 1);
    localparam int I_BASE = W_DEPTH * BEATS;

    typedef enum logic [2:0] {
        S_IDLE, S_W_ACC, S_W_GAP, S_R_ACC, S_R_GAP, S_R_SEND
    } state_t;

    state_t            r_state, w_next;
    logic [BW-1:0]     r_beat;
    logic              r_is_w;
    logic [WPW-1:0]    r_w_head, r_w_tail;
    logic [WCW-1:0]    r_w_cnt;
    logic [IPW-1:0]    r_i_head, r_i_tail;
    logic [ICW-1:0]    r_i_cnt;
    logic              r_wr_ack, r_occ_err;
    logic [1:0]        r_err_code;
    logic [DATA_W-1:0] r_rd_data;
    logic [DATA_W-1:0] r_o_mem [O_DEPTH];
    logic [OPW-1:0]    r_o_head, r_o_tail;
    logic [OCW-1:0]    r_o_cnt;

    logic              w_start, w_sel_w, w_wr_err, w_rd_err;
    logic              w_wr_done, w_rd_done, w_done, w_last;
    logic              w_o_full, w_o_pop, w_o_push, w_o_ovf;
    logic              w_err_any;
    logic [1:0]        w_err_code;
    logic [ADDR_W-1:0] w_slot, w_addr;

    assign w_done = (bus.sram_state == 2'd2);
    assign w_last = (r_beat == BW'(BEATS - 1));

    // Slot follows the tail for writes and the head for reads
    assign w_slot = (r_state == S_W_ACC)
                  ? (r_is_w ? ADDR_W'(r_w_tail) : ADDR_W'(r_i_tail))
                  : (r_is_w ? ADDR_W'(r_w_head) : ADDR_W'(r_i_head));
    assign w_addr = (r_is_w ? '0 : ADDR_W'(I_BASE))
                  + w_slot * ADDR_W'(BEATS) + ADDR_W'(r_beat);

    assign w_o_full = (r_o_cnt == OCW'(O_DEPTH));
    assign w_o_pop  = (r_o_cnt != '0) && bus.out_ready;
    assign w_o_push = bus.act_valid && (!w_o_full || w_o_pop);
    assign w_o_ovf  = bus.act_valid && w_o_full && !w_o_pop;

    assign w_err_any  = w_wr_err | w_rd_err | w_o_ovf;
    assign w_err_code = w_o_ovf ? 2'd3 : (w_rd_err ? 2'd2 : 2'd1);

    // State register; clear forces IDLE and aborts any access
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)         r_state <= S_IDLE;
        else if (bus.clear) r_state <= S_IDLE;
        else                r_state <= w_next;
    end

    // Next state and per-cycle control events
    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_sel_w   = r_is_w;
        w_wr_err  = 1'b0;
        w_rd_err  = 1'b0;
        w_wr_done = 1'b0;
        w_rd_done = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.sram_state == 2'd0) begin
                    if (bus.wr_req && !r_wr_ack) begin
                        w_sel_w = bus.wr_is_weight;
                        if (w_sel_w ? (r_w_cnt == WCW'(W_DEPTH))
                                    : (r_i_cnt == ICW'(I_DEPTH))) begin
                            w_wr_err = 1'b1;
                        end else begin
                            w_start = 1'b1;
                            w_next  = S_W_ACC;
                        end
                    end else if (bus.rd_w_req) begin
                        w_sel_w = 1'b1;
                        if (r_w_cnt == '0) w_rd_err = 1'b1;
                        else begin
                            w_start = 1'b1;
                            w_next  = S_R_ACC;
                        end
                    end else if (bus.rd_i_req) begin
                        w_sel_w = 1'b0;
                        if (r_i_cnt == '0) w_rd_err = 1'b1;
                        else begin
                            w_start = 1'b1;
                            w_next  = S_R_ACC;
                        end
                    end
                end
            end
            S_W_ACC: if (w_done) w_next = S_W_GAP;
            S_W_GAP: begin
                if (w_last) begin
                    w_next    = S_IDLE;
                    w_wr_done = 1'b1;
                end else begin
                    w_next = S_W_ACC;
                end
            end
            S_R_ACC: if (w_done) w_next = S_R_GAP;
            S_R_GAP: w_next = w_last ? S_R_SEND : S_R_ACC;
            S_R_SEND: begin
                if (bus.rd_ack) begin
                    w_next    = S_IDLE;
                    w_rd_done = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Beat counter, queue pointers/counts, read assembly and error reporting
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_beat <= '0; r_is_w <= 1'b0;
            r_w_head <= '0; r_w_tail <= '0; r_w_cnt <= '0;
            r_i_head <= '0; r_i_tail <= '0; r_i_cnt <= '0;
            r_wr_ack <= 1'b0; r_occ_err <= 1'b0; r_err_code <= 2'd0;
            r_rd_data <= '0;
        end else if (bus.clear) begin
            r_beat <= '0; r_is_w <= 1'b0;
            r_w_head <= '0; r_w_tail <= '0; r_w_cnt <= '0;
            r_i_head <= '0; r_i_tail <= '0; r_i_cnt <= '0;
            r_wr_ack <= 1'b0; r_occ_err <= 1'b0; r_err_code <= 2'd0;
            r_rd_data <= '0;
        end else begin
            r_wr_ack  <= w_wr_done | w_wr_err;
            r_occ_err <= w_err_any;
            if (w_err_any) r_err_code <= w_err_code;
            if (w_start) begin
                r_beat <= '0;
                r_is_w <= w_sel_w;
            end else if (r_state == S_W_GAP || r_state == S_R_GAP) begin
                r_beat <= r_beat + 1'b1;
            end
            if (r_state == S_R_ACC && w_done)
                r_rd_data[r_beat*SRAM_W +: SRAM_W] <= bus.sram_rdata;
            if (w_wr_done) begin
                if (r_is_w) begin
                    r_w_tail <= (r_w_tail == WPW'(W_DEPTH - 1)) ? '0 : r_w_tail + 1'b1;
                    r_w_cnt  <= r_w_cnt + 1'b1;
                end else begin
                    r_i_tail <= (r_i_tail == IPW'(I_DEPTH - 1)) ? '0 : r_i_tail + 1'b1;
                    r_i_cnt  <= r_i_cnt + 1'b1;
                end
            end
            if (w_rd_done) begin
                if (r_is_w) begin
                    r_w_head <= (r_w_head == WPW'(W_DEPTH - 1)) ? '0 : r_w_head + 1'b1;
                    r_w_cnt  <= r_w_cnt - 1'b1;
                end else begin
                    r_i_head <= (r_i_head == IPW'(I_DEPTH - 1)) ? '0 : r_i_head + 1'b1;
                    r_i_cnt  <= r_i_cnt - 1'b1;
                end
            end
        end
    end

    // Output FIFO pointers and occupancy
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_o_head <= '0; r_o_tail <= '0; r_o_cnt <= '0;
        end else if (bus.clear) begin
            r_o_head <= '0; r_o_tail <= '0; r_o_cnt <= '0;
        end else begin
            if (w_o_push)
                r_o_tail <= (r_o_tail == OPW'(O_DEPTH - 1)) ? '0 : r_o_tail + 1'b1;
            if (w_o_pop)
                r_o_head <= (r_o_head == OPW'(O_DEPTH - 1)) ? '0 : r_o_head + 1'b1;
            if (w_o_push && !w_o_pop)      r_o_cnt <= r_o_cnt + 1'b1;
            else if (w_o_pop && !w_o_push) r_o_cnt <= r_o_cnt - 1'b1;
        end
    end

    // Output FIFO storage; contents are don't-care while unoccupied
    always_ff @(posedge clk) begin
        if (w_o_push && !bus.clear) r_o_mem[r_o_tail] <= bus.act_data;
    end

    assign bus.sram_wen   = (r_state == S_W_ACC);
    assign bus.sram_ren   = (r_state == S_R_ACC);
    assign bus.sram_addr  = (bus.sram_wen || bus.sram_ren) ? w_addr : '0;
    assign bus.sram_wdata = bus.sram_wen ? bus.wr_data[r_beat*SRAM_W +: SRAM_W] : '0;
    assign bus.wr_ack     = r_wr_ack;
    assign bus.rd_valid   = (r_state == S_R_SEND);
    assign bus.rd_data    = r_rd_data;
    assign bus.out_valid  = (r_o_cnt != '0);
    assign bus.out_data   = r_o_mem[r_o_head];
    assign bus.w_count    = r_w_cnt;
    assign bus.i_count    = r_i_cnt;
    assign bus.o_count    = r_o_cnt;
    assign bus.occ_err    = r_occ_err;
    assign bus.err_code   = r_err_code;
endmodule
